noc_rr_port_arbiter: RTL and testbench
======================================

Name: noc_rr_port_arbiter

Overview:
- Wormhole round-robin arbiter for one NoC router output port.
- Shares the output link between NUM_REQ input ports and locks the grant from head flit through tail flit.
- Rotates a one-hot priority pointer after each completed packet.
- Reports per-packet flit counts to the router's stats logic.

Parameters:
- NUM_REQ, 4, number of requesting input ports.
- RESET_PRIO, 4'b0100, one-hot priority pointer value after reset (bit 2 highest).
- CNT_W, 8, width of the per-packet flit counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, synchronous, active-high.
- req_i  input  NUM_REQ  per-input flit-valid request toward this output.
- tail_i  input  NUM_REQ  current flit on that input is a tail flit; meaningful only when the matching req_i bit is 1.
- out_ready_i  input  1  downstream can accept a flit this cycle.
- grant_o  output  NUM_REQ  one-hot grant; all zero when unlocked.
- grant_valid_o  output  1  arbiter is locked to an input.
- fire_o  output  1  a flit transfers this cycle.
- priority_o  output  NUM_REQ  current one-hot priority pointer.
- pkt_done_o  output  1  one-cycle pulse, the cycle after a tail flit fires.
- pkt_flits_o  output  CNT_W  flit count of the packet just completed; valid when pkt_done_o=1.

Behaviour:
- Reset (synchronous, active-high) has priority over all other events. Reset state:
  - state = ARB_IDLE
  - grant_o = 0, grant_valid_o = 0, fire_o = 0
  - priority_o = RESET_PRIO
  - pkt_done_o = 0, pkt_flits_o = 0
  - internal flit counter = 0
- Reset mid-packet drops the lock with no pkt_done_o pulse.
- State machine:
  - ARB_IDLE: if req_i != 0, register the winner into grant_q and go to ARB_LOCKED. Otherwise stay.
  - Winner: the first set bit of req_i scanning upward from the priority_o bit index, wrapping from NUM_REQ-1 to 0.
  - Latency: grant_o asserts exactly 1 cycle after req_i is first seen in ARB_IDLE.
  - ARB_LOCKED: grant_o = grant_q, grant_valid_o = 1.
  - fire_o = |(grant_q & req_i) & out_ready_i (combinational).
- Transfers while locked:
  - On fire, counter increments and saturates at 2^CNT_W-1.
  - On fire with tail_i of the granted input set:
    - go to ARB_IDLE and clear grant_q;
    - priority_o <= grant_q rotated left by 1, with wrap (bit NUM_REQ-1 -> bit 0);
    - next cycle: pkt_done_o = 1, pkt_flits_o = counter + 1 (saturating); counter clears.
- Boundary conditions:
  - Locked, granted req_i low: lock held, no fire, counter unchanged. This covers bubbles inside a wormhole packet.
  - Locked, out_ready_i low: no fire, lock held, tail_i ignored.
  - tail_i set while the granted req_i is low: ignored.
  - Requests from non-granted inputs while locked have no effect and are not latched.
  - One idle bubble cycle always follows a released packet (ARB_IDLE re-arbitrates). No back-to-back grants.
  - Single-flit packet (head = tail on first fire): counter reports 1.
  - priority_o changes only on tail fire or reset. It stays one-hot at all times.
  - pkt_flits_o holds its last value when pkt_done_o = 0.

Decomposition:
- Package noc_arb_pkg holds:
  - NUM_REQ default constant;
  - typedef enum arb_state_t {ARB_IDLE, ARB_LOCKED};
  - function rotl1_onehot for the pointer rotation.
- Sub-module rr_priority_select is a natural split: a combinational one-hot pick from req and priority vectors with wrap-around. It is reusable by other ports' arbiters.

Test Plan:
- Reset, then req_i=1111 -> grant_o=0100 one cycle later; priority_o=0100 until the tail fires.
- Granted input 2 sends 3 flits (tail on 3rd), out_ready_i=1 -> fire_o 3 cycles; pkt_done_o=1 with pkt_flits_o=3; priority_o=1000; next grant_o=1000 after 1 bubble.
- Wrap-around: tail fires from grant 1000 -> priority_o=0001. With req_i=0110 the next grant is 0010.
- Stall and bubble: locked to input 1, toggle out_ready_i low 2 cycles and req_i[1] low 1 cycle, tail held during stall -> no fire, no release, lock held, count excludes stalled cycles.
- Single-flit packet from input 3 (req_i=1000, tail_i=1000) -> 1 fire; pkt_flits_o=1; priority_o=0001.
- Reset asserted mid-packet (after 2 of 4 flits) -> next cycle grant_o=0, priority_o=0100, no pkt_done_o; subsequent re-arbitration restarts the count at 0.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for NoC output-port arbiters.
package noc_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned MAX_REQ     = 32;
    localparam int unsigned MAX_IDX_W   = 5;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Rotate the low n bits of a one-hot vector left by one, wrapping bit n-1 to bit 0.
    function automatic logic [MAX_REQ-1:0] rotl1_onehot(
        input logic [MAX_REQ-1:0] v,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                r[MAX_IDX_W'((i + 1) % n)] = v[MAX_IDX_W'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// One-hot round-robin pick: first set req bit at or above the one-hot prio index, wrapping.
module rr_priority_select
    import noc_arb_pkg::*;
#(
    parameter int unsigned N = NUM_REQ_DEF
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] prio,
    output logic [N-1:0] grant_c
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    logic found;

    always_comb begin
        grant_c = '0;
        found   = 1'b0;
        for (int unsigned s = 0; s < N; s++) begin
            if (prio[IDX_W'(s)]) begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (!found && req[IDX_W'((s + k) % N)]) begin
                        grant_c[IDX_W'((s + k) % N)] = 1'b1;
                        found                        = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/noc_rr_port_arbiter.sv
// Wormhole round-robin arbiter for one router output port; holds the grant head-to-tail
// and reports per-packet flit counts.
module noc_rr_port_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned        NUM_REQ    = NUM_REQ_DEF,
    parameter logic [NUM_REQ-1:0] RESET_PRIO = NUM_REQ'(4'b0100),
    parameter int unsigned        CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] tail_i,
    input  logic               out_ready_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               grant_valid_o,
    output logic               fire_o,
    output logic [NUM_REQ-1:0] priority_o,
    output logic               pkt_done_o,
    output logic [CNT_W-1:0]   pkt_flits_o
);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] prio_q, prio_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   flits_q, flits_d;

    logic [NUM_REQ-1:0] pick_c;
    logic [NUM_REQ-1:0] prio_next_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic               fire_c;
    logic               tail_fire_c;

    rr_priority_select #(
        .N (NUM_REQ)
    ) u_pick (
        .req     (req_i),
        .prio    (prio_q),
        .grant_c (pick_c)
    );

    // grant_q is zero while idle, so no transfer can be flagged outside a lock.
    assign fire_c      = (|(grant_q & req_i)) & out_ready_i;
    assign tail_fire_c = fire_c & (|(grant_q & tail_i));
    assign cnt_inc_c   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign prio_next_c = NUM_REQ'(rotl1_onehot(MAX_REQ'(grant_q), NUM_REQ));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            prio_q  <= RESET_PRIO;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            flits_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            flits_q <= flits_d;
        end
    end

    // Next-state and datapath updates; pkt_done is a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        flits_d = flits_q;
        case (state_q)
            ARB_IDLE: begin
                if (|req_i) begin
                    grant_d = pick_c;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (tail_fire_c) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    prio_d  = prio_next_c;
                    done_d  = 1'b1;
                    flits_d = cnt_inc_c;
                    cnt_d   = '0;
                end else if (fire_c) begin
                    cnt_d = cnt_inc_c;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = (state_q == ARB_LOCKED);
    assign fire_o        = fire_c;
    assign priority_o    = prio_q;
    assign pkt_done_o    = done_q;
    assign pkt_flits_o   = flits_q;

endmodule

// File: tb/tb_noc_rr_port_arbiter.sv
// Randomised and directed bench for noc_rr_port_arbiter against an index-based packet model.
module tb_noc_rr_port_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned CW   = 8;
    localparam int          CMAX = 255;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] req_i;
    logic [NREQ-1:0] tail_i;
    logic            out_ready_i;
    logic [NREQ-1:0] grant_o;
    logic            grant_valid_o;
    logic            fire_o;
    logic [NREQ-1:0] priority_o;
    logic            pkt_done_o;
    logic [CW-1:0]   pkt_flits_o;

    int checks = 0;
    int errors = 0;

    // Model state: locked input index (-1 when free), priority index, flits so far.
    int m_lock;
    int m_prio;
    int m_cnt;
    bit m_done;
    int m_flits;

    noc_rr_port_arbiter #(
        .NUM_REQ    (NREQ),
        .RESET_PRIO (4'b0100),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_i         (req_i),
        .tail_i        (tail_i),
        .out_ready_i   (out_ready_i),
        .grant_o       (grant_o),
        .grant_valid_o (grant_valid_o),
        .fire_o        (fire_o),
        .priority_o    (priority_o),
        .pkt_done_o    (pkt_done_o),
        .pkt_flits_o   (pkt_flits_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_fire(input logic [NREQ-1:0] rq, input logic rdy);
        return (m_lock >= 0) && rq[m_lock] && rdy;
    endfunction

    task automatic model_step(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] tl,
                              input logic rdy, input logic rst);
        if (rst) begin
            m_lock = -1; m_prio = 2; m_cnt = 0; m_done = 0; m_flits = 0;
        end else begin
            m_done = 0;
            if (m_lock < 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_lock < 0 && rq[(m_prio + k) % NREQ]) m_lock = (m_prio + k) % NREQ;
                end
            end else if (model_fire(rq, rdy)) begin
                if (tl[m_lock]) begin
                    m_flits = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
                    m_done  = 1;
                    m_cnt   = 0;
                    m_prio  = (m_lock + 1) % NREQ;
                    m_lock  = -1;
                end else begin
                    m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
                end
            end
        end
    endtask

    // Drive one cycle's inputs, compare all outputs mid-cycle, then advance the model at the edge.
    task automatic do_cycle(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] tl,
                            input logic rdy, input logic rst);
        logic [NREQ-1:0] exp_grant;
        logic [NREQ-1:0] exp_prio;
        @(negedge clk);
        req_i = rq; tail_i = tl; out_ready_i = rdy; reset = rst;
        #1;
        exp_grant = '0;
        if (m_lock >= 0) exp_grant[m_lock] = 1'b1;
        exp_prio = '0;
        exp_prio[m_prio] = 1'b1;
        check_eq("grant", 32'(grant_o), 32'(exp_grant));
        check_eq("grant_valid", 32'(grant_valid_o), 32'(m_lock >= 0));
        check_eq("fire", 32'(fire_o), 32'(model_fire(rq, rdy)));
        check_eq("priority", 32'(priority_o), 32'(exp_prio));
        check_eq("prio_onehot", 32'($onehot(priority_o)), 32'd1);
        check_eq("pkt_done", 32'(pkt_done_o), 32'(m_done));
        check_eq("pkt_flits", 32'(pkt_flits_o), 32'(m_flits));
        @(posedge clk);
        model_step(rq, tl, rdy, rst);
    endtask

    initial begin
        req_i = '0; tail_i = '0; out_ready_i = 1'b0; reset = 1'b1;
        m_lock = -1; m_prio = 2; m_cnt = 0; m_done = 0; m_flits = 0;

        do_cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
        do_cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
        do_cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

        // All request: input 2 wins, sends 3 flits; then input 3 wins after one bubble.
        do_cycle(4'b1111, 4'b0000, 1'b1, 1'b0);
        do_cycle(4'b1111, 4'b0000, 1'b1, 1'b0);
        do_cycle(4'b1111, 4'b0000, 1'b1, 1'b0);
        do_cycle(4'b1111, 4'b0100, 1'b1, 1'b0);
        check_eq("three_flit_count", 32'(pkt_flits_o), 32'd0);
        do_cycle(4'b1111, 4'b0000, 1'b1, 1'b0);
        check_eq("three_flit_done", 32'(pkt_flits_o), 32'd3);
        // Single flit from input 3 wraps the pointer to input 0.
        do_cycle(4'b1111, 4'b1000, 1'b1, 1'b0);
        do_cycle(4'b0110, 4'b0000, 1'b1, 1'b0);
        check_eq("wrap_priority", 32'(priority_o), 32'b0001);

        // Locked to input 1: stalls, a bubble, held tail, then tail fires.
        do_cycle(4'b0110, 4'b0000, 1'b1, 1'b0);
        do_cycle(4'b0010, 4'b0010, 1'b0, 1'b0);
        do_cycle(4'b0010, 4'b0010, 1'b0, 1'b0);
        do_cycle(4'b1101, 4'b0010, 1'b1, 1'b0);
        do_cycle(4'b0010, 4'b0010, 1'b1, 1'b0);
        do_cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        check_eq("stall_count", 32'(pkt_flits_o), 32'd2);

        // Single-flit packet from input 3.
        do_cycle(4'b1000, 4'b1000, 1'b1, 1'b0);
        do_cycle(4'b1000, 4'b1000, 1'b1, 1'b0);
        do_cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        check_eq("single_flit", 32'(pkt_flits_o), 32'd1);

        // Reset after 2 of 4 flits, then a fresh packet.
        do_cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
        do_cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
        do_cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
        do_cycle(4'b0001, 4'b0000, 1'b1, 1'b1);
        do_cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
        do_cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
        do_cycle(4'b0001, 4'b0001, 1'b1, 1'b0);
        do_cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

        // Long packet to exercise counter saturation.
        for (int i = 0; i < 300; i++) do_cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
        do_cycle(4'b0001, 4'b0001, 1'b1, 1'b0);
        do_cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        check_eq("saturated_count", 32'(pkt_flits_o), 32'd255);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            do_cycle(NREQ'($urandom), NREQ'($urandom & $urandom),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
